divu_hilo: RTL and testbench

Sequential unsigned 32-bit divider that owns the HI/LO register pair consumed by the datapath's MFHI/MFLO reads. It complements the combinational ALU: the ALU handles single-cycle ops, and this block runs the multi-cycle DIVU function. It writes quotient to LO and remainder to HI, then serves them back on a read port keyed by the same 6-bit function code the ALU receives.

---
 rtl/divu_hilo.sv | 159 +++++++++++++++
 tb/tb_divu_hilo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/divu_hilo.sv
// divu_hilo: multi-cycle unsigned 32-bit restoring divider that owns the HI/LO
// register pair. LO receives the quotient and HI the remainder. Both are read
// back through a result port keyed by the ALU function code.
module divu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [4:0] LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic [WIDTH:0]   trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;

    // Launch condition: DIVU request while the divider is not iterating.
    always_comb begin
        accept_s = 1'b0;
        if (start && (ctl == FN_DIVU) && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // One restoring step: shift the next dividend bit into the remainder, then
    // subtract the divisor when it fits. The compare uses the full 33-bit trial
    // value. The remainder that results always fits in 32 bits.
    always_comb begin
        trial_s  = {rem_r, quo_r[WIDTH-1]};
        ge_s     = (trial_s >= {1'b0, divisor_r});
        rem_nx_s = trial_s[WIDTH-1:0];
        quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        if (ge_s) begin
            rem_nx_s = trial_s[WIDTH-1:0] - divisor_r;
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx_s = trial_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic. A zero divisor skips RUN and completes immediately.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nx_s = (b == {WIDTH{1'b0}}) ? DONE : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register, with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Datapath: load working registers on accept, iterate in RUN, and commit HI/LO on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor_r <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            cnt_r     <= 5'd0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            dbz_r     <= 1'b0;
        end else if (accept_s) begin
            divisor_r <= b;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= a;
            cnt_r     <= 5'd0;
            dbz_r     <= (b == {WIDTH{1'b0}});
            if (b == {WIDTH{1'b0}}) begin
                lo_r <= {WIDTH{1'b1}};
                hi_r <= a;
            end
        end else if (state_r == RUN) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == LAST_STEP) begin
                lo_r <= quo_nx_s;
                hi_r <= rem_nx_s;
            end
        end
    end

    // Read port: select HI or LO by function code. Any other code reads as zero.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (ctl)
            FN_MFHI: result = hi_r;
            FN_MFLO: result = lo_r;
            default: result = {WIDTH{1'b0}};
        endcase
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_divu_hilo.sv
// Self-checking bench for divu_hilo. A transaction-level model uses native
// '/' and '%' with a 32-cycle countdown. It is compared against the DUT on
// every falling edge. Directed scenarios add hand-computed literal checks.
module tb_divu_hilo;

    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int tests;
    int fails;

    divu_hilo dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctl(ctl), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .result(result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dbz  = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_q    = 32'd0;
    logic [31:0] p_r    = 32'd0;
    int          m_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_hi = p_r; m_lo = p_q;
            end else begin
                m_done = 1'b0;
            end
        end else if (start && ctl == FN_DIVU) begin
            m_dbz = (b == 32'd0);
            if (b == 32'd0) begin
                m_hi = a; m_lo = 32'hFFFF_FFFF; m_done = 1'b1;
            end else begin
                p_q = a / b; p_r = a % b; m_left = 32; m_busy = 1'b1; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        logic [31:0] m_res;
        m_res = (ctl == FN_MFHI) ? m_hi : (ctl == FN_MFLO) ? m_lo : 32'd0;
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("result", result, m_res);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] da, input logic [31:0] db);
        start = 1'b1; ctl = FN_DIVU; a = da; b = db;
        tick();
        start = 1'b0; ctl = 6'd0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; ctl = 6'd0; a = 32'd0; b = 32'd0;
        tick(); tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 100 / 7: busy for exactly 32 cycles, then done
        issue(32'd100, 32'd7);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, 32'd32);
        chk("done_after_busy", {31'd0, done}, 32'd1);
        chk("q_100_7", lo, 32'd14);
        chk("r_100_7", hi, 32'd2);
        chk("dbz_100_7", {31'd0, div_by_zero}, 32'd0);
        tick();

        // FFFFFFFF / 1, then 5 / 9 issued back-to-back from DONE
        issue(32'hFFFF_FFFF, 32'd1);
        wait_done("done_ffff_1");
        chk("q_ffff_1", lo, 32'hFFFF_FFFF);
        chk("r_ffff_1", hi, 32'd0);
        issue(32'd5, 32'd9);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("done_5_9");
        chk("q_5_9", lo, 32'd0);
        chk("r_5_9", hi, 32'd5);
        tick();

        // Divide by zero completes in one cycle; the next divide clears the flag
        issue(32'd1234, 32'd0);
        chk("dz_done", {31'd0, done}, 32'd1);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'd1234);
        chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
        tick();
        issue(32'd8, 32'd2);
        chk("dz_clear", {31'd0, div_by_zero}, 32'd0);
        wait_done("done_8_2");
        chk("q_8_2", lo, 32'd4);
        chk("r_8_2", hi, 32'd0);
        tick();

        // 1000 / 3 with an ignored start mid-run; reads return the old values
        issue(32'd1000, 32'd3);
        repeat (9) tick();
        start = 1'b1; ctl = FN_DIVU; a = 32'd9; b = 32'd3;
        tick();
        start = 1'b0;
        ctl = FN_MFLO;
        #1 chk("mid_mflo_old", result, 32'd4);
        ctl = FN_MFHI;
        #1 chk("mid_mfhi_old", result, 32'd0);
        ctl = 6'd0;
        wait_done("done_1000_3");
        chk("q_1000_3", lo, 32'd333);
        chk("r_1000_3", hi, 32'd1);
        tick();

        // Reset mid-run aborts, then a fresh divide works
        issue(32'd12345, 32'd17);
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_flags", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        issue(32'd50, 32'd5);
        wait_done("done_50_5");
        chk("q_50_5", lo, 32'd10);
        chk("r_50_5", hi, 32'd0);
        tick();

        // Read port selection, and start with a non-DIVU code
        issue(32'd100, 32'd7);
        wait_done("done_100_7b");
        tick();
        ctl = FN_MFHI;
        #1 chk("mfhi", result, 32'd2);
        ctl = FN_MFLO;
        #1 chk("mflo", result, 32'd14);
        ctl = 6'b100000;
        #1 chk("other_fn", result, 32'd0);
        start = 1'b1; ctl = FN_MFLO;
        tick();
        chk("start_mflo_idle", {31'd0, busy}, 32'd0);
        start = 1'b0; ctl = 6'd0;
        tick();

        // A large divisor makes the remainder's top bit significant
        issue(32'hFFFF_FFFE, 32'h8000_0001);
        wait_done("done_big");
        chk("q_big", lo, 32'd1);
        chk("r_big", hi, 32'h7FFF_FFFD);
        tick();
        issue(32'hDEAD_BEEF, 32'h0001_0000);
        wait_done("done_shift");
        chk("q_shift", lo, 32'h0000_DEAD);
        chk("r_shift", hi, 32'h0000_BEEF);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
